hub75_bank_scheduler: RTL and testbench
=======================================

Name: hub75_bank_scheduler

Overview:
- Sequences the double-buffered pixel RAM between the SPI frame writer and the HUB75 scan-out engine.
- Tracks writer frame boundaries and scan-out row progress. Swaps read/write banks only at a display frame boundary after a complete frame has been written, so the panel never shows a torn frame.
- Counts dropped frames and raises a blank request when the display has shown stale data for too long.

Parameters:
- NUM_ROWS, 16, scan rows per displayed frame (row_done pulses per frame); ≥2.
- STALE_FRAMES, 255, display frames without a swap before stale/blank asserts; 1..255.
- CNT_WIDTH, 8, width of overrun_count.

Ports:
- clk  input  1  system clock.
- reset  input  1  asynchronous, active-high reset.
- wr_frame_start  input  1  1-cycle pulse: writer begins a frame into the bank given by wr_bank (already synchronised to clk upstream).
- wr_frame_done  input  1  1-cycle pulse: writer finished the frame.
- rd_row_done  input  1  1-cycle pulse: scan-out finished all bitplanes of one row.
- wr_bank  output  1  bank the writer must use; always ~rd_bank.
- rd_bank  output  1  bank scan-out reads.
- wr_ready  output  1  high when the writer may start a frame.
- swap_pulse  output  1  1-cycle pulse in the cycle after a bank swap.
- frame_pending  output  1  complete frame waiting for swap.
- row_index  output  4  current scan row, 0..NUM_ROWS-1.
- overrun_count  output  CNT_WIDTH  saturating dropped-frame count.
- stale  output  1  STALE_FRAMES display frames elapsed without a swap.

Behaviour:
- Reset values (asynchronous, active-high):
  - state IDLE; rd_bank 0 (so wr_bank 1).
  - wr_ready 1; swap_pulse 0; frame_pending 0.
  - row_index 0; overrun_count 0; stale 0; internal stale counter 0.
- Row counter: increments on rd_row_done. At NUM_ROWS-1 it wraps to 0 and raises internal frame_end in that same cycle (combinational from rd_row_done and row_index==NUM_ROWS-1).
- State machine (all transitions on posedge clk):
  - IDLE: wr_ready=1.
    - wr_frame_start -> WRITING.
    - wr_frame_done alone is ignored.
  - WRITING: wr_ready=0.
    - wr_frame_done -> PENDING.
    - A repeated wr_frame_start stays in WRITING and is not an error.
  - PENDING: frame_pending=1, wr_ready=0.
    - frame_end -> SWAP; rd_bank toggles on this edge.
    - wr_frame_start without frame_end: the pending frame is dropped, overrun_count +1 (saturating at all-ones), -> WRITING into the same bank.
    - frame_end and wr_frame_start in the same cycle: the swap wins (-> SWAP), the start is discarded, and overrun_count +1.
  - SWAP: one cycle; swap_pulse=1, wr_ready=0 -> IDLE. A wr_frame_start here is discarded and overrun_count +1.
- Output timing: frame_pending and wr_ready are combinational decodes of state. rd_bank and overrun_count are registered. Consequences:
  - rd_bank changes exactly one cycle after the frame_end cycle.
  - swap_pulse is high in the cycle rd_bank first shows the new value.
- wr_bank is the combinational ~rd_bank. The writer latches it at wr_frame_start.
- Stale logic:
  - The counter increments on each frame_end that does not cause a swap, saturating at STALE_FRAMES.
  - The counter clears on the swap edge.
  - stale = (counter == STALE_FRAMES), registered. It drops the cycle after the swap edge.
- Simultaneous rd_row_done and any writer pulse: both are processed in the same cycle. Row counting is never stalled.
- Reset mid-frame: everything returns to reset values immediately. No swap or pulse is generated, and the partial writer frame is abandoned.
- No combinational path from writer inputs to rd_bank.

Test Plan:
- Reset, then start; done; 16 rd_row_done pulses -> rd_bank goes 0→1 one cycle after the 16th pulse, swap_pulse high that same cycle, wr_bank=0, frame_pending low, state IDLE (wr_ready=1 the cycle after swap_pulse).
- Start; done; another start before any frame_end -> overrun_count=1, frame_pending=0, rd_bank stays 0; then done and 16 rows -> swap to rd_bank=1.
- PENDING with the 16th rd_row_done and wr_frame_start in the same cycle -> swap occurs, overrun_count increments by 1, state IDLE afterwards.
- STALE_FRAMES=3, no writer activity, 48 row pulses -> stale asserts after the 3rd frame_end; a full frame plus swap then drops stale one cycle after the swap edge.
- Force 300 overruns with CNT_WIDTH=8 -> overrun_count saturates at 255.
- Assert reset during WRITING with row_index=9 -> row_index 0, rd_bank 0, wr_ready 1, no swap_pulse; done pulses after reset are ignored.

Source files
------------

// File: rtl/hub75_bank_scheduler.sv
// Double-buffer bank scheduler between the SPI frame writer and HUB75 scan-out.
// Latency: rd_bank/overrun_count/stale registered (1 cycle); wr_ready/frame_pending/swap_pulse decode state.
// Backpressure: wr_ready low while a frame is in flight or pending; early starts drop the pending frame and count an overrun.
module hub75_bank_scheduler #(
   parameter int NUM_ROWS     = 16,
   parameter int STALE_FRAMES = 255,
   parameter int CNT_WIDTH    = 8
) (
   input  logic                 clk,
   input  logic                 reset,
   input  logic                 wr_frame_start,
   input  logic                 wr_frame_done,
   input  logic                 rd_row_done,
   output logic                 wr_bank,
   output logic                 rd_bank,
   output logic                 wr_ready,
   output logic                 swap_pulse,
   output logic                 frame_pending,
   output logic [3:0]           row_index,
   output logic [CNT_WIDTH-1:0] overrun_count,
   output logic                 stale
);

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      WRITING = 2'd1,
      PENDING = 2'd2,
      SWAP    = 2'd3
   } state_t;

   localparam logic [3:0]           LAST_ROW  = 4'(NUM_ROWS - 1);
   localparam logic [7:0]           STALE_MAX = 8'(STALE_FRAMES);
   localparam logic [CNT_WIDTH-1:0] CNT_MAX   = {CNT_WIDTH{1'b1}};

   state_t     state;
   state_t     state_next;
   logic       frame_end;
   logic       do_swap;
   logic       overrun_inc;
   logic [7:0] stale_cnt;
   logic [7:0] stale_cnt_next;

   // Last row of a display frame completing marks the only point a swap may happen.
   assign frame_end   = rd_row_done && (row_index == LAST_ROW);
   assign do_swap     = (state == PENDING) && frame_end;
   // Any start while a finished frame is pending or being swapped in loses a frame.
   assign overrun_inc = wr_frame_start && ((state == PENDING) || (state == SWAP));
   assign wr_bank     = ~rd_bank;

   // State register.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= IDLE;
      else       state <= state_next;
   end

   // Next-state logic; a swap beats a coincident writer start.
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (wr_frame_start) state_next = WRITING;
         WRITING: if (wr_frame_done)  state_next = PENDING;
         PENDING: begin
            if (frame_end)           state_next = SWAP;
            else if (wr_frame_start) state_next = WRITING;
         end
         SWAP:    state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   // Output decode of state.
   always_comb begin
      wr_ready      = 1'b0;
      frame_pending = 1'b0;
      swap_pulse    = 1'b0;
      case (state)
         IDLE:    wr_ready      = 1'b1;
         PENDING: frame_pending = 1'b1;
         SWAP:    swap_pulse    = 1'b1;
         default: ;
      endcase
   end

   // Scan row counter; never stalled by writer activity.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)            row_index <= 4'd0;
      else if (frame_end)   row_index <= 4'd0;
      else if (rd_row_done) row_index <= row_index + 4'd1;
   end

   // Read bank flips on the swap edge so the new value appears with swap_pulse.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)        rd_bank <= 1'b0;
      else if (do_swap) rd_bank <= ~rd_bank;
   end

   // Saturating dropped-frame counter.
   always_ff @(posedge clk or posedge reset) begin
      if (reset)                                    overrun_count <= '0;
      else if (overrun_inc && overrun_count != CNT_MAX) overrun_count <= overrun_count + 1'b1;
   end

   // Stale counter next value: clear on swap, count non-swapping frame ends up to the limit.
   always_comb begin
      stale_cnt_next = stale_cnt;
      if (do_swap)
         stale_cnt_next = 8'd0;
      else if (frame_end && stale_cnt != STALE_MAX)
         stale_cnt_next = stale_cnt + 8'd1;
   end

   // Stale counter and its registered flag, taken from the updated count.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stale_cnt <= 8'd0;
         stale     <= 1'b0;
      end else begin
         stale_cnt <= stale_cnt_next;
         stale     <= (stale_cnt_next == STALE_MAX);
      end
   end

endmodule

// File: tb/tb_hub75_bank_scheduler.sv
// Directed bench for hub75_bank_scheduler (NUM_ROWS=16, STALE_FRAMES=3, CNT_WIDTH=8).
// Inputs driven 1 time unit after posedge; outputs sampled at the same point.
// Every comparison goes through check_val.
module tb_hub75_bank_scheduler;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       wr_frame_start = 1'b0;
   logic       wr_frame_done = 1'b0;
   logic       rd_row_done = 1'b0;
   logic       wr_bank;
   logic       rd_bank;
   logic       wr_ready;
   logic       swap_pulse;
   logic       frame_pending;
   logic [3:0] row_index;
   logic [7:0] overrun_count;
   logic       stale;

   int n_cmp = 0;
   int n_bad = 0;

   hub75_bank_scheduler #(
      .NUM_ROWS(16),
      .STALE_FRAMES(3),
      .CNT_WIDTH(8)
   ) dut (
      .clk(clk),
      .reset(reset),
      .wr_frame_start(wr_frame_start),
      .wr_frame_done(wr_frame_done),
      .rd_row_done(rd_row_done),
      .wr_bank(wr_bank),
      .rd_bank(rd_bank),
      .wr_ready(wr_ready),
      .swap_pulse(swap_pulse),
      .frame_pending(frame_pending),
      .row_index(row_index),
      .overrun_count(overrun_count),
      .stale(stale)
   );

   always #5 clk = ~clk;

   task automatic check_val(input string tag, input int got, input int exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   // One clock with the given pulses; returns 1 unit after the edge.
   task automatic cyc(input logic s, input logic d, input logic r);
      wr_frame_start = s;
      wr_frame_done  = d;
      rd_row_done    = r;
      @(posedge clk);
      #1;
      wr_frame_start = 1'b0;
      wr_frame_done  = 1'b0;
      rd_row_done    = 1'b0;
   endtask

   task automatic rows(input int n);
      for (int i = 0; i < n; i++) cyc(1'b0, 1'b0, 1'b1);
   endtask

   task automatic do_reset();
      #2 reset = 1'b1;
      #10 reset = 1'b0;
      @(posedge clk);
      #1;
   endtask

   initial begin
      // Reset values
      #3;
      check_val("rst_rd_bank", rd_bank, 0);
      check_val("rst_wr_bank", wr_bank, 1);
      check_val("rst_wr_ready", wr_ready, 1);
      check_val("rst_swap", swap_pulse, 0);
      check_val("rst_pending", frame_pending, 0);
      check_val("rst_row", row_index, 0);
      check_val("rst_ovr", overrun_count, 0);
      check_val("rst_stale", stale, 0);
      do_reset();

      // Basic frame write and swap
      cyc(1'b1, 1'b0, 1'b0);
      check_val("t1_wr_ready_writing", wr_ready, 0);
      cyc(1'b0, 1'b1, 1'b0);
      check_val("t1_pending", frame_pending, 1);
      rows(15);
      check_val("t1_row15", row_index, 15);
      check_val("t1_rd_bank_pre", rd_bank, 0);
      check_val("t1_swap_pre", swap_pulse, 0);
      rows(1);
      check_val("t1_rd_bank", rd_bank, 1);
      check_val("t1_swap", swap_pulse, 1);
      check_val("t1_wr_bank", wr_bank, 0);
      check_val("t1_pending_post", frame_pending, 0);
      check_val("t1_row_wrap", row_index, 0);
      check_val("t1_wr_ready_swap", wr_ready, 0);
      cyc(1'b0, 1'b0, 1'b0);
      check_val("t1_wr_ready_idle", wr_ready, 1);
      check_val("t1_swap_gone", swap_pulse, 0);
      check_val("t1_rd_bank_hold", rd_bank, 1);

      // Overrun by early restart
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      cyc(1'b1, 1'b0, 1'b0);
      check_val("t2_ovr", overrun_count, 1);
      check_val("t2_pending", frame_pending, 0);
      check_val("t2_rd_bank", rd_bank, 0);
      check_val("t2_wr_ready", wr_ready, 0);
      cyc(1'b0, 1'b1, 1'b0);
      rows(16);
      check_val("t2_rd_bank_swap", rd_bank, 1);
      check_val("t2_swap", swap_pulse, 1);

      // Swap and start collide on the last row
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      rows(15);
      cyc(1'b1, 1'b0, 1'b1);
      check_val("t3_rd_bank", rd_bank, 1);
      check_val("t3_swap", swap_pulse, 1);
      check_val("t3_ovr", overrun_count, 1);
      cyc(1'b0, 1'b0, 1'b0);
      check_val("t3_idle", wr_ready, 1);
      check_val("t3_ovr_hold", overrun_count, 1);

      // Stale after three swapless frames, cleared by a swap
      do_reset();
      rows(47);
      check_val("t4_stale_pre", stale, 0);
      rows(1);
      check_val("t4_stale", stale, 1);
      cyc(1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0);
      rows(15);
      check_val("t4_stale_hold", stale, 1);
      rows(1);
      check_val("t4_swap", swap_pulse, 1);
      check_val("t4_stale_clear", stale, 0);

      // Overrun saturation
      do_reset();
      cyc(1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 200; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         cyc(1'b1, 1'b0, 1'b0);
      end
      check_val("t5_ovr200", overrun_count, 200);
      for (int i = 0; i < 100; i++) begin
         cyc(1'b0, 1'b1, 1'b0);
         cyc(1'b1, 1'b0, 1'b0);
      end
      check_val("t5_ovr_sat", overrun_count, 255);

      // Reset mid-frame
      do_reset();
      cyc(1'b1, 1'b0, 1'b1);
      rows(8);
      check_val("t6_row9", row_index, 9);
      check_val("t6_writing", wr_ready, 0);
      #2 reset = 1'b1;
      #1;
      check_val("t6_row_rst", row_index, 0);
      check_val("t6_rd_bank_rst", rd_bank, 0);
      check_val("t6_wr_ready_rst", wr_ready, 1);
      check_val("t6_swap_rst", swap_pulse, 0);
      @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;
      cyc(1'b0, 1'b1, 1'b0);
      check_val("t6_done_ignored_pend", frame_pending, 0);
      check_val("t6_done_ignored_rdy", wr_ready, 1);
      rows(16);
      check_val("t6_no_swap", rd_bank, 0);
      check_val("t6_row_wrap", row_index, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
